// File: rtl/status_pkg.sv
// Shared types for the ZNCV status controller: condition codes, flag bit positions,
// controller states and the branch-condition evaluator.
package status_pkg;

    localparam int ZF = 3;
    localparam int NF = 2;
    localparam int CF = 1;
    localparam int VF = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CLR  = 1'b1
    } ctrl_state_e;

    function automatic logic eval_cond(cond_e c, logic [3:0] f);
        logic z, n, cf, v;
        z  = f[ZF];
        n  = f[NF];
        cf = f[CF];
        v  = f[VF];
        case (c)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return cf;
            COND_CC: return !cf;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return cf && !z;
            COND_LS: return !cf || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            COND_NV: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/status_ctrl_if.sv
// Request/response bundle between the core control unit (master) and the status
// controller (slave); also carries the status register readback.
interface status_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic          alu_valid_i;
    logic [3:0]    alu_zncv_i;
    logic          wr_valid_i;
    logic [3:0]    wr_zncv_i;
    logic          irq_enter_i;
    logic          irq_exit_i;
    logic [3:0]    flags_i;
    logic [3:0]    cond_i;
    logic          load_en_o;
    logic [3:0]    zncv_o;
    logic          cond_true_o;
    logic          busy_o;
    logic [DW-1:0] depth_o;
    logic          stack_full_o;
    logic          stack_empty_o;
    logic          ovf_err_o;
    logic          unf_err_o;

    modport master (
        output alu_valid_i, alu_zncv_i, wr_valid_i, wr_zncv_i,
               irq_enter_i, irq_exit_i, flags_i, cond_i,
        input  load_en_o, zncv_o, cond_true_o, busy_o, depth_o,
               stack_full_o, stack_empty_o, ovf_err_o, unf_err_o
    );

    modport slave (
        input  alu_valid_i, alu_zncv_i, wr_valid_i, wr_zncv_i,
               irq_enter_i, irq_exit_i, flags_i, cond_i,
        output load_en_o, zncv_o, cond_true_o, busy_o, depth_o,
               stack_full_o, stack_empty_o, ovf_err_o, unf_err_o
    );

endinterface

// File: rtl/status_ctrl_flag_stack.sv
// LIFO of saved ZNCV values for nested interrupts. Occupancy saturates at 0 and DEPTH;
// a push while full or a pop while empty is dropped and reported with a one-cycle pulse.
module flag_stack #(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [3:0]                   data_i,
    output logic [3:0]                   top_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         ovf_o,
    output logic                         unf_o
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [DW-1:0] depth_q, depth_d;

    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign ovf_o   = push_i && full_o;
    assign unf_o   = pop_i && empty_o;
    assign depth_o = depth_q;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        mem_d   = mem_q;
        depth_d = depth_q;
        top_o   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) top_o = mem_q[i];
        end
        if (push_i && !full_o) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (depth_q == DW'(i)) mem_d[i] = data_i;
            end
            depth_d = depth_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q <= '0;
            // NOTE: the stack is small and its contents must read as zero after reset, so it is reset like any flop.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/status_ctrl.sv
// Sequences every write to the ZNCV status register (ALU, explicit write, interrupt
// save/restore) and evaluates branch conditions on the forwarded flags.
module status_ctrl #(
    parameter int DEPTH      = 4,
    parameter bit CLR_ON_IRQ = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    status_ctrl_if.slave bus
);
    import status_pkg::*;

    localparam int DW = $clog2(DEPTH + 1);

    ctrl_state_e   state_q, state_d;
    logic          armed_q, armed_d;
    logic          load_en_q, load_en_d;
    logic [3:0]    zncv_q, zncv_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          push, pop;
    logic [3:0]    fwd;
    logic [3:0]    stk_top;
    logic [DW-1:0] stk_depth;
    logic          stk_full, stk_empty, stk_ovf, stk_unf;
    logic          accept;

    flag_stack #(.DEPTH(DEPTH)) u_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (fwd),
        .top_o   (stk_top),
        .depth_o (stk_depth),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .ovf_o   (stk_ovf),
        .unf_o   (stk_unf)
    );

    // A load issued last cycle has not reached the register yet, so it overrides flags_i.
    assign fwd    = load_en_q ? zncv_q : bus.flags_i;
    assign accept = armed_q && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        armed_d   = 1'b1;
        load_en_d = 1'b0;
        zncv_d    = '0;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_d     = ovf_q | stk_ovf;
        unf_d     = unf_q | stk_unf;
        if (state_q == CLR) begin
            load_en_d = 1'b1;
            zncv_d    = '0;
            state_d   = IDLE;
        end else if (accept) begin
            if (bus.irq_exit_i) begin
                pop = 1'b1;
                if (!stk_empty) begin
                    load_en_d = 1'b1;
                    zncv_d    = stk_top;
                end
            end else if (bus.irq_enter_i) begin
                push = 1'b1;
                if (CLR_ON_IRQ) state_d = CLR;
            end else if (bus.wr_valid_i) begin
                load_en_d = 1'b1;
                zncv_d    = bus.wr_zncv_i;
            end else if (bus.alu_valid_i) begin
                load_en_d = 1'b1;
                zncv_d    = bus.alu_zncv_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            load_en_q <= 1'b0;
            zncv_q    <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            armed_q   <= armed_d;
            load_en_q <= load_en_d;
            zncv_q    <= zncv_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Held busy while reset is released but the first edge has not yet armed the controller.
    assign bus.busy_o        = rst_ni && (!armed_q || (state_q == CLR));
    assign bus.load_en_o     = load_en_q;
    assign bus.zncv_o        = zncv_q;
    assign bus.cond_true_o   = eval_cond(cond_e'(bus.cond_i), fwd);
    assign bus.depth_o       = stk_depth;
    assign bus.stack_full_o  = stk_full;
    assign bus.stack_empty_o = stk_empty;
    assign bus.ovf_err_o     = ovf_q;
    assign bus.unf_err_o     = unf_q;

endmodule

// File: tb/tb_status_ctrl.sv
// Randomized and directed bench for status_ctrl against a transaction-level model
// (queue-based flag stack, scheduled register loads) compared on every falling edge.
module tb_status_ctrl;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    status_ctrl_if #(.DEPTH(DEPTH)) bus ();

    status_ctrl #(.DEPTH(DEPTH), .CLR_ON_IRQ(1'b1)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [3:0] m_stack [$];
    logic       m_first;
    logic       m_clr;
    logic       m_load;
    logic [3:0] m_zncv;
    logic       m_ovf;
    logic       m_unf;

    // Conditions come in complementary pairs; odd codes negate the even base condition.
    function automatic logic ref_cond(int code, logic [3:0] f);
        logic z, n, c, v, base;
        {z, n, c, v} = f;
        case (code / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c & ~z;
            5: base = (n == v);
            6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (code % 2 == 1) ? ~base : base;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic       nl;
        logic [3:0] nz;
        logic [3:0] f;
        if (!rst_n) begin
            m_stack.delete();
            m_first = 1'b1;
            m_clr   = 1'b0;
            m_load  = 1'b0;
            m_zncv  = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            nl = 1'b0;
            nz = '0;
            f  = m_load ? m_zncv : bus.flags_i;
            if (m_clr) begin
                nl    = 1'b1;
                m_clr = 1'b0;
            end else if (!m_first) begin
                if (bus.irq_exit_i) begin
                    if (m_stack.size() > 0) begin
                        nz = m_stack.pop_back();
                        nl = 1'b1;
                    end else m_unf = 1'b1;
                end else if (bus.irq_enter_i) begin
                    if (m_stack.size() < DEPTH) m_stack.push_back(f);
                    else m_ovf = 1'b1;
                    m_clr = 1'b1;
                end else if (bus.wr_valid_i) begin
                    nl = 1'b1;
                    nz = bus.wr_zncv_i;
                end else if (bus.alu_valid_i) begin
                    nl = 1'b1;
                    nz = bus.alu_zncv_i;
                end
            end
            m_first = 1'b0;
            m_load  = nl;
            m_zncv  = nz;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        logic [3:0] f;
        if (rst_n === 1'b1) begin
            f = m_load ? m_zncv : bus.flags_i;
            check("load_en",   32'(bus.load_en_o),     32'(m_load));
            check("zncv",      32'(bus.zncv_o),        32'(m_zncv));
            check("busy",      32'(bus.busy_o),        32'(m_first | m_clr));
            check("depth",     32'(bus.depth_o),       32'(m_stack.size()));
            check("full",      32'(bus.stack_full_o),  32'(m_stack.size() == DEPTH));
            check("empty",     32'(bus.stack_empty_o), 32'(m_stack.size() == 0));
            check("ovf",       32'(bus.ovf_err_o),     32'(m_ovf));
            check("unf",       32'(bus.unf_err_o),     32'(m_unf));
            check("cond_true", 32'(bus.cond_true_o),   32'(ref_cond(int'(bus.cond_i), f)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.alu_valid_i = 1'b0;
        bus.alu_zncv_i  = '0;
        bus.wr_valid_i  = 1'b0;
        bus.wr_zncv_i   = '0;
        bus.irq_enter_i = 1'b0;
        bus.irq_exit_i  = 1'b0;
        bus.flags_i     = '0;
        bus.cond_i      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check("rst_load_en", 32'(bus.load_en_o), 32'd0);
        check("rst_depth",   32'(bus.depth_o),   32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("first_busy", 32'(bus.busy_o), 32'd1);
        tick();
        check("armed_busy", 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle_inputs();
        do_reset();

        // ALU load lands one cycle later, then clears.
        bus.alu_valid_i = 1'b1;
        bus.alu_zncv_i  = 4'b1010;
        tick();
        idle_inputs();
        check("t1_load", 32'(bus.load_en_o), 32'd1);
        check("t1_zncv", 32'(bus.zncv_o),    32'hA);
        tick();
        check("t1_idle", 32'(bus.load_en_o), 32'd0);

        // Interrupt entry saves flags_i, clears, exit restores.
        bus.flags_i     = 4'b0110;
        bus.irq_enter_i = 1'b1;
        tick();
        idle_inputs();
        check("t2_depth", 32'(bus.depth_o), 32'd1);
        check("t2_busy",  32'(bus.busy_o),  32'd1);
        tick();
        check("t2_clr_load", 32'(bus.load_en_o), 32'd1);
        check("t2_clr_zncv", 32'(bus.zncv_o),    32'd0);
        bus.irq_exit_i = 1'b1;
        tick();
        idle_inputs();
        check("t2_pop_zncv",  32'(bus.zncv_o),  32'h6);
        check("t2_pop_depth", 32'(bus.depth_o), 32'd0);

        // Push uses the forwarded (in-flight) value, not stale flags_i.
        bus.wr_valid_i = 1'b1;
        bus.wr_zncv_i  = 4'b0001;
        tick();
        idle_inputs();
        bus.flags_i     = 4'b1111;
        bus.irq_enter_i = 1'b1;
        tick();
        idle_inputs();
        check("t3_depth", 32'(bus.depth_o), 32'd1);
        tick();
        bus.irq_exit_i = 1'b1;
        tick();
        idle_inputs();
        check("t3_fwd_push", 32'(bus.zncv_o), 32'h1);

        // Five entries into a four-deep stack, then five exits.
        for (int k = 1; k <= 5; k++) begin
            bus.irq_enter_i = 1'b1;
            tick();
            idle_inputs();
            tick();
            if (k == 4) begin
                check("t4_full4",  32'(bus.stack_full_o), 32'd1);
                check("t4_noovf",  32'(bus.ovf_err_o),    32'd0);
            end
        end
        check("t4_ovf",   32'(bus.ovf_err_o), 32'd1);
        check("t4_depth", 32'(bus.depth_o),   32'd4);
        bus.irq_exit_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) check("t4_nounf", 32'(bus.unf_err_o), 32'd0);
        end
        idle_inputs();
        check("t4_unf",    32'(bus.unf_err_o), 32'd1);
        check("t4_depth0", 32'(bus.depth_o),   32'd0);

        // All requests at once with depth 1: only the pop happens.
        do_reset();
        bus.flags_i     = 4'b0101;
        bus.irq_enter_i = 1'b1;
        tick();
        idle_inputs();
        tick();
        bus.irq_exit_i  = 1'b1;
        bus.irq_enter_i = 1'b1;
        bus.wr_valid_i  = 1'b1;
        bus.wr_zncv_i   = 4'b1111;
        bus.alu_valid_i = 1'b1;
        bus.alu_zncv_i  = 4'b1100;
        tick();
        idle_inputs();
        check("t5_zncv",  32'(bus.zncv_o),  32'h5);
        check("t5_depth", 32'(bus.depth_o), 32'd0);
        check("t5_busy",  32'(bus.busy_o),  32'd0);
        tick();
        check("t5_nolatch", 32'(bus.load_en_o), 32'd0);

        // Reset asserted in the middle of the clear cycle.
        bus.irq_enter_i = 1'b1;
        tick();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy",  32'(bus.busy_o),    32'd0);
        check("t5_rst_depth", 32'(bus.depth_o),   32'd0);
        check("t5_rst_load",  32'(bus.load_en_o), 32'd0);
        check("t5_rst_zncv",  32'(bus.zncv_o),    32'd0);
        check("t5_rst_errs",  32'({bus.ovf_err_o, bus.unf_err_o}), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Randomized traffic, alternating push-heavy and pop-heavy phases.
        for (int b = 0; b < 4; b++) begin
            int pe, px;
            do_reset();
            pe = (b % 2 == 1) ? 8 : 20;
            px = (b % 2 == 1) ? 20 : 8;
            for (int c = 0; c < 600; c++) begin
                bus.irq_exit_i  = ($urandom_range(0, 99) < px);
                bus.irq_enter_i = ($urandom_range(0, 99) < pe);
                bus.wr_valid_i  = ($urandom_range(0, 99) < 30);
                bus.alu_valid_i = ($urandom_range(0, 99) < 50);
                bus.wr_zncv_i   = 4'($urandom);
                bus.alu_zncv_i  = 4'($urandom);
                bus.flags_i     = 4'($urandom);
                bus.cond_i      = 4'($urandom);
                tick();
            end
        end

        // Full condition-code sweep on register flags.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                @(negedge clk);
                bus.cond_i  = 4'(c);
                bus.flags_i = 4'(f);
                #1;
                check("cond_sweep", 32'(bus.cond_true_o), 32'(ref_cond(c, 4'(f))));
            end
        end
        check("cond_ge_lit", 32'(ref_cond(10, 4'b0101)), 32'd1);
        check("cond_hi_lit", 32'(ref_cond(8, 4'b1010)),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
